acc_unit: RTL
=============

# acc_unit

Parametrised accumulator for the custom CPU datapath; the successor to the original 10-bit load/clear accumulator register. It holds a WIDTH-bit accumulator and executes one operation per handshake: load, add, subtract, AND, OR, clear, multi-cycle serial shifts, and push/pop to a small LIFO save stack. Status flags are exported to the control unit. It sits between the ALU operand bus and the control FSM, and stalls the control FSM during shifts via `op_ready`.

## Interface

Parameters:
- `WIDTH`, 10, accumulator and operand width (≥ 4)
- `STACK_DEPTH`, 4, LIFO entries (≥ 2; ignored unless stack compiled in)
- `SHAMT_W`, 4, shift-amount width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `op_valid`  in  1  operation request
- `op_ready`  out  1  block can accept an op this cycle
- `op`  in  4  opcode (see Operation)
- `operand`  in  WIDTH  data for LOAD/ADD/SUB/AND/OR
- `shamt`  in  SHAMT_W  shift distance for SHL/SHR
- `acc`  out  WIDTH  accumulator value
- `flag_z`  out  1  acc == 0 (combinational from acc)
- `flag_n`  out  1  acc[WIDTH-1] (combinational)
- `flag_c`  out  1  registered carry/borrow/shift-out bit
- `flag_v`  out  1  registered signed overflow
- `stk_empty`  out  1  stack empty
- `stk_full`  out  1  stack full
- `err`  out  1  one-cycle pulse on illegal op or stack fault

## Operation

- An op is accepted on a rising edge with `op_valid && op_ready`. Ops presented while `op_ready` is low are ignored; the requester holds them.
- Opcodes:
  - 0 NOP
  - 1 LOAD (acc←operand)
  - 2 ADD
  - 3 SUB (acc−operand)
  - 4 AND
  - 5 OR
  - 6 CLR
  - 7 SHL (logical)
  - 8 SHR (arithmetic)
  - 9 PUSH
  - 10 POP
  - 11–15 illegal: `err`, no state change
- Flags:
  - ADD: c = carry out; v = signed overflow.
  - SUB: c = borrow (operand > acc, unsigned); v = signed overflow.
  - LOAD/AND/OR/CLR/POP: c and v cleared.
  - NOP, PUSH and illegal ops: c and v unchanged.
- Arithmetic is modulo 2^WIDTH.
- Shift FSM with two states, IDLE and SHIFT:
  - `op_ready` = 1 only in IDLE.
  - On accept with shamt = k > 0: the first 1-bit shift happens on the accept edge and cnt ← k−1. If cnt > 0, go to SHIFT.
  - In SHIFT: each edge shifts 1 bit and decrements cnt; return to IDLE after the edge where cnt reaches 0.
  - c = the last bit shifted out; v cleared.
  - shamt = 0: acc unchanged, c and v unchanged, stays IDLE.
- PUSH when full, or POP when empty: `err` pulses; acc, stack and flags are unchanged.
- Reset (async, at any time, including mid-shift):
  - acc = 0, flags c and v = 0, state = IDLE, stack emptied.
  - Outputs: `op_ready` = 1, `flag_z` = 1, `flag_n` = 0, `stk_empty` = 1, `stk_full` = 0, `err` = 0.

## Timing

- Single-cycle ops: `acc` and the flags show the result in the cycle after the accept edge.
- Shift by k: result visible k cycles after the accept edge; `op_ready` is low for k−1 cycles.
- PUSH/POP: stack pointer and `acc` update on the accept edge; `stk_full`/`stk_empty` are registered and update on the same edge.
- `err` is high for exactly the one cycle following the offending accept edge.
- Back-to-back single-cycle ops are accepted every cycle with no bubbles.

## Configuration

- `ACC_STACK_EN` defined: the LIFO of STACK_DEPTH×WIDTH is instantiated, and PUSH/POP behave as above.
- `ACC_STACK_EN` undefined:
  - No stack storage.
  - PUSH and POP are illegal ops: `err` pulses, no state change.
  - `stk_empty` is tied to 1 and `stk_full` is tied to 0.

## Structure

- Package `acc_pkg` holds:
  - the opcode enum `acc_op_e` (4-bit);
  - the FSM state enum `acc_state_e`;
  - the default parameter constants.
- Sub-module `acc_stack`:
  - parametrised LIFO with push/pop/data_in/data_out/full/empty;
  - instantiated only under `ACC_STACK_EN`.
- Flag logic and the shift FSM stay in `acc_unit`.

## Test plan

All scenarios use WIDTH = 10 and STACK_DEPTH = 4.

1. Reset, then LOAD 0x1FF, ADD 0x001 → acc = 0x200, c = 0, v = 1, n = 1; then SUB 0x201 → acc = 0x3FF, c = 1, v = 0.
2. LOAD 0x3FF, ADD 0x002 → acc = 0x001, c = 1, v = 0, z = 0; CLR → acc = 0, z = 1, c = 0.
3. LOAD 0x281, SHR shamt = 3 → `op_ready` low for 2 cycles, acc = 0x3D0, c = 0; then SHL shamt = 0 → acc unchanged, no stall.
4. Assert `rst` during the second cycle of an SHL by 5 → acc = 0 and `op_ready` = 1 immediately; the next LOAD 0x055 is accepted normally.
5. PUSH 0x011, 0x022, 0x033, 0x044 → `stk_full` = 1; a fifth PUSH → `err` pulse, stack unchanged; POP ×4 → acc sequence 0x044, 0x033, 0x022, 0x011, then `stk_empty` = 1; a fifth POP → `err`, acc stays 0x011.
6. Opcode 13 → `err` for one cycle, acc and flags unchanged. Without `ACC_STACK_EN`, PUSH → `err`.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared opcodes, FSM states and default sizes
// for the acc_unit accumulator slice.
package acc_pkg;

    localparam int ACC_WIDTH_D = 10;
    localparam int ACC_DEPTH_D = 4;
    localparam int ACC_SHAMT_D = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LOAD = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_CLR  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_PUSH = 4'd9,
        OP_POP  = 4'd10
    } acc_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } acc_state_e;

endpackage

// File: rtl/acc_stack.sv
// acc_stack: small LIFO save stack for the accumulator.
// Full/empty derive directly from the registered pointer.
module acc_stack
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH_D,
    parameter int DEPTH = ACC_DEPTH_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;

    assign full     = (ptr == PW'(DEPTH));
    assign empty    = (ptr == '0);
    assign data_out = mem[IW'(ptr - P_ONE)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + P_ONE;
        end else if (pop && !empty) begin
            ptr <= ptr - P_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[IW'(ptr)] <= data_in;
        end
    end

endmodule

// File: rtl/acc_unit.sv
// acc_unit: parametrised accumulator with flags, serial shifts
// and an optional LIFO save stack (compiled in by ACC_STACK_EN).
module acc_unit
    import acc_pkg::*;
#(
    parameter int WIDTH       = ACC_WIDTH_D,
    parameter int STACK_DEPTH = ACC_DEPTH_D,
    parameter int SHAMT_W     = ACC_SHAMT_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   acc,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_c,
    output logic               flag_v,
    output logic               stk_empty,
    output logic               stk_full,
    output logic               err
);

    localparam int MSB = WIDTH - 1;
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    acc_state_e state, state_nxt;

    logic [SHAMT_W-1:0] cnt;
    logic               dir_r;
    logic               fire;
    logic               shift_go;
    logic               illegal;
    logic               stk_pop;
    logic               stk_fault;
    logic [WIDTH-1:0]   stk_dout;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic               add_v;
    logic               sub_v;
    logic               sh_right;
    logic [WIDTH-1:0]   sh_acc;
    logic               sh_out;

    assign fire     = op_valid && op_ready;
    assign shift_go = fire && (op == OP_SHL || op == OP_SHR)
                      && (shamt != '0);
    assign illegal  = (op > OP_POP);

    assign sum   = {1'b0, acc} + {1'b0, operand};
    assign dif   = {1'b0, acc} - {1'b0, operand};
    assign add_v = (acc[MSB] == operand[MSB]) && (sum[MSB] != acc[MSB]);
    assign sub_v = (acc[MSB] != operand[MSB]) && (dif[MSB] != acc[MSB]);

    // Direction comes from the opcode on the accept edge, then from dir_r.
    assign sh_right = (state == ST_SHIFT) ? dir_r : (op == OP_SHR);
    assign sh_acc   = sh_right ? {acc[MSB], acc[MSB:1]}
                               : {acc[MSB-1:0], 1'b0};
    assign sh_out   = sh_right ? acc[0] : acc[MSB];

    assign flag_z = (acc == '0);
    assign flag_n = acc[MSB];

`ifdef ACC_STACK_EN
    logic stk_push;

    assign stk_push  = fire && (op == OP_PUSH) && !stk_full;
    assign stk_pop   = fire && (op == OP_POP) && !stk_empty;
    assign stk_fault = fire && (((op == OP_PUSH) && stk_full) ||
                                ((op == OP_POP) && stk_empty));

    acc_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (stk_push),
        .pop      (stk_pop),
        .data_in  (acc),
        .data_out (stk_dout),
        .full     (stk_full),
        .empty    (stk_empty)
    );
`else
    assign stk_pop   = 1'b0;
    assign stk_dout  = '0;
    assign stk_fault = fire && (op == OP_PUSH || op == OP_POP);
    assign stk_empty = 1'b1;
    // No storage compiled in, so the stack can never report full.
    assign stk_full  = (STACK_DEPTH < 1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (shift_go && shamt != CNT_ONE) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
            dir_r  <= 1'b0;
        end else begin
            err <= stk_fault || (fire && illegal);
            if (state == ST_SHIFT) begin
                acc    <= sh_acc;
                flag_c <= sh_out;
                cnt    <= cnt - CNT_ONE;
            end else if (fire) begin
                case (op)
                    OP_LOAD: begin
                        acc    <= operand;
                        flag_c <= 1'b0;
                        flag_v <= 1'b0;
                    end
                    OP_ADD: begin
                        acc    <= sum[MSB:0];
                        flag_c <= sum[WIDTH];
                        flag_v <= add_v;
                    end
                    OP_SUB: begin
                        acc    <= dif[MSB:0];
                        flag_c <= dif[WIDTH];
                        flag_v <= sub_v;
                    end
                    OP_AND: begin
                        acc    <= acc & operand;
                        flag_c <= 1'b0;
                        flag_v <= 1'b0;
                    end
                    OP_OR: begin
                        acc    <= acc | operand;
                        flag_c <= 1'b0;
                        flag_v <= 1'b0;
                    end
                    OP_CLR: begin
                        acc    <= '0;
                        flag_c <= 1'b0;
                        flag_v <= 1'b0;
                    end
                    OP_SHL, OP_SHR: begin
                        if (shamt != '0) begin
                            acc    <= sh_acc;
                            flag_c <= sh_out;
                            flag_v <= 1'b0;
                            cnt    <= shamt - CNT_ONE;
                            dir_r  <= (op == OP_SHR);
                        end
                    end
                    OP_POP: begin
                        if (stk_pop) begin
                            acc    <= stk_dout;
                            flag_c <= 1'b0;
                            flag_v <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
